zynet_argmax: RTL and testbench

- Downstream classification stage for the zyNet output vector.
- Accepts the full OUTPUT_SIZE-word signed fixed-point score vector via zyNet's valid/yumi handshake and scans it sequentially, one word per cycle.
- Presents the winning class index, its score, and the top-1/top-2 margin on a valid/ready handshake to the host-side result logic.
- Frees zyNet's output register as soon as the vector is captured.

---
 rtl/zynet_argmax.sv | 112 +++++++++++
 tb/tb_zynet_argmax.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zynet_argmax.sv
// zynet_argmax: top-1 classifier for the zyNet score vector.
// Captures the whole vector in one cycle, then scans it one word per cycle while tracking the
// best and second-best signed scores. The result is presented on a valid/ready handshake.
module zynet_argmax #(
  parameter int unsigned OUTPUT_SIZE = 10,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned IDX_W       = $clog2(OUTPUT_SIZE)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  valid_i,
  output logic                                  yumi_o,
  input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [IDX_W-1:0]                      class_o,
  output logic [WORD_SIZE-1:0]                  score_o,
  output logic [WORD_SIZE-1:0]                  margin_o
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic signed [WORD_SIZE-1:0] MinScore  = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic [WORD_SIZE:0]          MaxMargin = {2'b00, {(WORD_SIZE-1){1'b1}}};
  localparam logic [IDX_W-1:0]            LastIdx   = IDX_W'(OUTPUT_SIZE - 1);

  state_e                                state_q;
  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] vec_q;
  logic signed [WORD_SIZE-1:0]           best_q, best_d;
  logic signed [WORD_SIZE-1:0]           second_q, second_d;
  logic signed [WORD_SIZE-1:0]           cur;
  logic [IDX_W-1:0]                      idx_q;
  logic [IDX_W-1:0]                      cls_q, cls_d;
  logic [WORD_SIZE:0]                    diff;
  logic [WORD_SIZE-1:0]                  margin_d;

  // Upstream is released the same cycle the vector is captured.
  always_comb begin
    yumi_o = valid_i && (state_q == StIdle);
  end

  // Top-2 update for the current element plus the saturated margin of the updated pair.
  always_comb begin
    cur      = vec_q[idx_q];
    best_d   = best_q;
    second_d = second_q;
    cls_d    = cls_q;
    // Strict compare keeps the lowest index on ties; an equal later value becomes second.
    if (cur > best_q) begin
      second_d = best_q;
      best_d   = cur;
      cls_d    = idx_q;
    end else if (cur > second_q) begin
      second_d = cur;
    end
    // One extra bit so best - second never wraps; the result is always non-negative.
    diff     = {best_d[WORD_SIZE-1], best_d} - {second_d[WORD_SIZE-1], second_d};
    margin_d = (diff > MaxMargin) ? {1'b0, {(WORD_SIZE-1){1'b1}}} : diff[WORD_SIZE-1:0];
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      cls_q    <= '0;
      idx_q    <= '0;
      valid_o  <= 1'b0;
      class_o  <= '0;
      score_o  <= '0;
      margin_o <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            vec_q    <= data_i;
            best_q   <= data_i[0];
            second_q <= MinScore;
            cls_q    <= '0;
            idx_q    <= IDX_W'(1);
            state_q  <= StScan;
          end
        end
        StScan: begin
          best_q   <= best_d;
          second_q <= second_d;
          cls_q    <= cls_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            valid_o  <= 1'b1;
            class_o  <= cls_d;
            score_o  <= best_d;
            margin_o <= margin_d;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zynet_argmax.sv
// Self-checking bench for zynet_argmax: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a latency-based behavioural model.
module tb_zynet_argmax;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][W-1:0] vec_t;

  logic          clk;
  logic          reset_i;
  logic          valid_i;
  logic          yumi_o;
  vec_t          data_i;
  logic          valid_o;
  logic          ready_i;
  logic [IW-1:0] class_o;
  logic [W-1:0]  score_o;
  logic [W-1:0]  margin_o;

  int checks;
  int errors;
  int cyc;
  bit cmp_en;

  // Model state: phase 0 = free, 1 = computing, 2 = result offered.
  int            m_phase;
  int            m_cnt;
  bit            m_valid;
  logic [IW-1:0] m_class;
  logic [W-1:0]  m_score;
  logic [W-1:0]  m_margin;
  logic [IW-1:0] p_class;
  logic [W-1:0]  p_score;
  logic [W-1:0]  p_margin;

  zynet_argmax #(
    .OUTPUT_SIZE(N),
    .WORD_SIZE  (W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .yumi_o  (yumi_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .class_o (class_o),
    .score_o (score_o),
    .margin_o(margin_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: winner is the first maximum; second is the largest of all remaining entries.
  task automatic ref_argmax(input vec_t v, output logic [IW-1:0] c, output logic [W-1:0] s,
                            output logic [W-1:0] m);
    int bi;
    int bv;
    int sv;
    int d;
    bi = 0;
    bv = $signed(v[0]);
    for (int k = 1; k < N; k++) begin
      if (int'($signed(v[k])) > bv) begin
        bi = k;
        bv = $signed(v[k]);
      end
    end
    sv = -(1 << (W - 1));
    for (int k = 0; k < N; k++) begin
      if (k != bi && int'($signed(v[k])) > sv) sv = $signed(v[k]);
    end
    d = bv - sv;
    if (d > (1 << (W - 1)) - 1) d = (1 << (W - 1)) - 1;
    c = IW'(bi);
    s = v[bi];
    m = d[W-1:0];
  endtask

  function automatic vec_t fill(input logic [W-1:0] val);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = val;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   mode;
    int   r;
    mode = $urandom_range(0, 3);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: r = $urandom;
        1: r = int'($urandom_range(0, 4)) - 2;
        2: begin
          case ($urandom_range(0, 3))
            0: r = 32'h8000;
            1: r = 32'h7FFF;
            2: r = 0;
            default: r = 32'hFFFF;
          endcase
        end
        default: r = int'($urandom_range(0, 3)) * 32'h1000;
      endcase
      v[k] = r[W-1:0];
    end
    return v;
  endfunction

  // Behavioural model: result appears N cycles after acceptance and is held until taken.
  initial begin
    m_phase  = 0;
    m_cnt    = 0;
    m_valid  = 0;
    m_class  = '0;
    m_score  = '0;
    m_margin = '0;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        m_phase  = 0;
        m_valid  = 0;
        m_class  = '0;
        m_score  = '0;
        m_margin = '0;
      end else if (m_phase == 0) begin
        if (valid_i) begin
          ref_argmax(data_i, p_class, p_score, p_margin);
          m_cnt   = N - 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid  = 1;
          m_class  = p_class;
          m_score  = p_score;
          m_margin = p_margin;
          m_phase  = 2;
        end
      end else if (ready_i) begin
        m_valid = 0;
        m_phase = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("yumi", yumi_o, 32'((m_phase == 0) && valid_i));
        check("valid", valid_o, 32'(m_valid));
        if (m_valid) begin
          check("class", class_o, m_class);
          check("score", score_o, m_score);
          check("margin", margin_o, m_margin);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  // Offer v until accepted; returns at the drive point of the cycle after acceptance.
  task automatic accept_vec(input vec_t v, output int t_acc);
    bit found;
    found   = 0;
    t_acc   = 0;
    valid_i = 1'b1;
    data_i  = v;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (yumi_o) begin
        found = 1;
        t_acc = cyc;
      end
    end
    if (!found) check("accept_timeout", 0, 1);
    drive_edge();
    valid_i = 1'b0;
    data_i  = rand_vec();
  endtask

  // Wait (bounded) for valid_o; returns at the negedge where it was seen.
  task automatic wait_valid(output int t_v);
    bit found;
    found = 0;
    t_v   = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_o) begin
        found = 1;
        t_v   = cyc;
      end
    end
    if (!found) check("valid_timeout", 0, 1);
  endtask

  task automatic run_directed(input string nm, input vec_t v, input logic [IW-1:0] ec,
                              input logic [W-1:0] es, input logic [W-1:0] em);
    int ta;
    int tv;
    ready_i = 1'b1;
    accept_vec(v, ta);
    wait_valid(tv);
    check({nm, "_latency"}, tv - ta, N);
    check({nm, "_class"}, class_o, ec);
    check({nm, "_score"}, score_o, es);
    check({nm, "_margin"}, margin_o, em);
    drive_edge();
  endtask

  initial begin
    vec_t          v1, v2, v3, v6, va, vb;
    logic [IW-1:0] c;
    logic [W-1:0]  s;
    logic [W-1:0]  m;
    int            ta;
    int            tv;
    int            tb;

    clk     = 1'b0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    cmp_en  = 0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;

    v1 = fill(16'h0100);
    v1[7] = 16'h1800;
    v1[3] = 16'h1000;
    v2 = fill(16'hF000);
    v2[2] = 16'h0C00;
    v2[5] = 16'h0C00;
    v3 = fill(16'h8000);
    v3[0] = 16'h7FFF;
    v6 = fill(16'hFFFF);

    // Pin the reference model against hand-computed results.
    ref_argmax(v1, c, s, m);
    check("pin1_class", c, 7);
    check("pin1_score", s, 16'h1800);
    check("pin1_margin", m, 16'h0800);
    ref_argmax(v2, c, s, m);
    check("pin2_class", c, 2);
    check("pin2_margin", m, 16'h0000);
    ref_argmax(v3, c, s, m);
    check("pin3_margin", m, 16'h7FFF);
    ref_argmax(fill(16'h8000), c, s, m);
    check("pin_allmin_class", c, 0);
    check("pin_allmin_margin", m, 0);

    // Reset state.
    drive_edge();
    cmp_en = 1;
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_yumi", yumi_o, 0);
    check("rst_class", class_o, 0);
    check("rst_score", score_o, 0);
    check("rst_margin", margin_o, 0);
    drive_edge();
    reset_i = 1'b0;

    run_directed("t1", v1, 7, 16'h1800, 16'h0800);
    run_directed("t2", v2, 2, 16'h0C00, 16'h0000);
    run_directed("t3", v3, 0, 16'h7FFF, 16'h7FFF);

    // Backpressure with a second vector waiting on valid_i.
    va = fill(16'h0010);
    va[9] = 16'h0200;
    va[4] = 16'h0100;
    vb = fill(16'h0040);
    vb[6] = 16'h0050;
    ready_i = 1'b0;
    accept_vec(va, ta);
    wait_valid(tv);
    check("t4a_latency", tv - ta, N);
    for (int st = 1; st < 20; st++) begin
      drive_edge();
      valid_i = 1'b1;
      data_i  = vb;
      @(negedge clk);
      check("t4_stall_yumi", yumi_o, 0);
      check("t4_stall_valid", valid_o, 1);
      check("t4_stall_class", class_o, 9);
      check("t4_stall_score", score_o, 16'h0200);
      check("t4_stall_margin", margin_o, 16'h0100);
    end
    drive_edge();
    ready_i = 1'b1;
    @(negedge clk);
    check("t4_xfer_valid", valid_o, 1);
    check("t4_xfer_yumi", yumi_o, 0);
    drive_edge();
    ready_i = 1'b0;
    @(negedge clk);
    check("t4_b_yumi", yumi_o, 1);
    check("t4_b_valid", valid_o, 0);
    tb = cyc;
    drive_edge();
    valid_i = 1'b0;
    data_i  = rand_vec();
    ready_i = 1'b1;
    wait_valid(tv);
    check("t4b_latency", tv - tb, N);
    check("t4b_class", class_o, 6);
    check("t4b_score", score_o, 16'h0050);
    check("t4b_margin", margin_o, 16'h0010);
    drive_edge();

    // Reset in the middle of a scan.
    accept_vec(v1, ta);
    repeat (3) drive_edge();
    reset_i = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    check("t5_rst_yumi", yumi_o, 0);
    drive_edge();
    reset_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("t5_no_valid", valid_o, 0);
    end
    drive_edge();
    run_directed("t6", v6, 0, 16'hFFFF, 16'h0000);
    run_directed("t_allmin", fill(16'h8000), 0, 16'h8000, 16'h0000);

    // Randomized traffic: random valid, ready, data and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive_edge();
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = $urandom_range(0, 1) == 1;
      data_i  = rand_vec();
      reset_i = ($urandom_range(0, 299) == 0);
    end
    drive_edge();
    reset_i = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
